// File: rtl/alu_slice_seq_if.sv
// Operand/result handshake bundle for alu_slice_seq.
// Both sides: a transfer happens on a rising edge where valid and ready are both high.
interface alu_slice_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             m;
  logic [3:0]       s;
  logic             crin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             crout;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, m, s, crin, a, b, out_ready,
    input  in_ready, out_valid, f, crout, zero, err
  );

  modport slave (
    input  in_valid, m, s, crin, a, b, out_ready,
    output in_ready, out_valid, f, crout, zero, err
  );
endinterface

// File: rtl/alu_slice_seq.sv
// Bit-serial-by-slice ALU: WIDTH-bit operands pass through one SLICE-bit datapath,
// LSB slice first, with the carry chained through a register between cycles.
module alu_slice_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_slice_seq_if.slave      bus,
  output logic [1:0]          state
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           st;
  logic             m_q;
  logic [3:0]       s_q;
  logic             illegal_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;

  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] y;
  logic [SLICE:0]   sum;
  logic             c_next;
  logic [WIDTH-1:0] acc_next;

  assign state = st;

  function automatic logic is_legal(input logic mode, input logic [3:0] sel);
    if (mode)
      return (sel == 4'h1) || (sel == 4'h6) || (sel == 4'hB) ||
             (sel == 4'hA) || (sel == 4'hE) || (sel == 4'hF);
    else
      return (sel == 4'h9) || (sel == 4'h6);
  endfunction

  // One slice of the datapath; illegal ops force a zero slice and no carry.
  always_comb begin
    sa     = a_sh[SLICE-1:0];
    sb     = b_sh[SLICE-1:0];
    sum    = '0;
    y      = '0;
    c_next = 1'b0;
    if (!illegal_q) begin
      if (m_q) begin
        case (s_q)
          4'h1:    y = ~(sa | sb);
          4'h6:    y = sa ^ sb;
          4'hB:    y = sa & sb;
          4'hA:    y = sb;
          4'hE:    y = sa | sb;
          4'hF:    y = sa;
          default: y = '0;
        endcase
      end else begin
        if (s_q == 4'h6)
          sum = {1'b0, sa} + {1'b0, ~sb} + {{SLICE{1'b0}}, carry_q};
        else
          sum = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, carry_q};
        y      = sum[SLICE-1:0];
        c_next = sum[SLICE];
      end
    end
    // Slices enter at the top and shift down, so slice 0 ends at the LSBs.
    acc_next = (acc >> SLICE) | (WIDTH'(y) << (WIDTH - SLICE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.f         <= '0;
      bus.crout     <= 1'b0;
      bus.zero      <= 1'b0;
      bus.err       <= 1'b0;
      m_q           <= 1'b0;
      s_q           <= '0;
      illegal_q     <= 1'b0;
      carry_q       <= 1'b0;
      cnt           <= '0;
      a_sh          <= '0;
      b_sh          <= '0;
      acc           <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            m_q          <= bus.m;
            s_q          <= bus.s;
            illegal_q    <= !is_legal(bus.m, bus.s);
            carry_q      <= bus.m ? 1'b0 : bus.crin;
            a_sh         <= bus.a;
            b_sh         <= bus.b;
            acc          <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            st           <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> SLICE;
          b_sh    <= b_sh >> SLICE;
          acc     <= acc_next;
          carry_q <= c_next;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(NSLICE - 1)) begin
            bus.f         <= acc_next;
            bus.crout     <= c_next;
            bus.zero      <= (acc_next == '0);
            bus.err       <= illegal_q;
            bus.out_valid <= 1'b1;
            st            <= DONE;
          end
        end
        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            st            <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_slice_seq.sv
// Directed bench for alu_slice_seq (WIDTH=16, SLICE=4): vector table plus
// backpressure, operand-change-during-RUN and mid-RUN reset sequences.
module tb_alu_slice_seq;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  int         errors;
  int         checks;

  alu_slice_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_slice_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [3:0]  s;
    logic        crin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_f;
    logic        exp_c;
    logic        exp_z;
    logic        exp_e;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic m, input logic [3:0] s, input logic crin,
                          input logic [15:0] a, input logic [15:0] b);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.m = m; bus.s = s; bus.crin = crin; bus.a = a; bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("post_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("post_state", {30'b0, state}, 32'd0);
  endtask

  initial begin
    int lat;
    errors = 0;
    checks = 0;
    //            m  s     cin a        b        f        c  z  e
    vecs[0]  = '{0, 4'h9, 0, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0};
    vecs[1]  = '{0, 4'h9, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0};
    vecs[2]  = '{0, 4'h6, 1, 16'h1234, 16'h0234, 16'h1000, 1, 0, 0};
    vecs[3]  = '{0, 4'h6, 1, 16'h0001, 16'h0002, 16'hFFFF, 0, 0, 0};
    vecs[4]  = '{1, 4'h1, 0, 16'h0F0F, 16'h00FF, 16'hF000, 0, 0, 0};
    vecs[5]  = '{1, 4'h6, 0, 16'h0F0F, 16'h00FF, 16'h0FF0, 0, 0, 0};
    vecs[6]  = '{0, 4'h3, 0, 16'h1234, 16'h5678, 16'h0000, 0, 1, 1};
    vecs[7]  = '{1, 4'hB, 0, 16'h0F0F, 16'h00FF, 16'h000F, 0, 0, 0};
    vecs[8]  = '{1, 4'hA, 0, 16'h0F0F, 16'h00FF, 16'h00FF, 0, 0, 0};
    vecs[9]  = '{1, 4'hE, 0, 16'h0F0F, 16'h00FF, 16'h0FFF, 0, 0, 0};
    vecs[10] = '{1, 4'hF, 1, 16'h0F0F, 16'h00FF, 16'h0F0F, 0, 0, 0};
    vecs[11] = '{1, 4'h9, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 1, 1};
    vecs[12] = '{0, 4'h9, 1, 16'h7FFF, 16'h8000, 16'h0000, 1, 1, 0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.m = 1'b0; bus.s = 4'h0; bus.crin = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_f", {16'b0, bus.f}, 32'd0);
    chk("rst_flags", {29'b0, bus.crout, bus.zero, bus.err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].m, vecs[i].s, vecs[i].crin, vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd4);
      chk($sformatf("v%0d_f", i), {16'b0, bus.f}, {16'b0, vecs[i].exp_f});
      chk($sformatf("v%0d_crout", i), {31'b0, bus.crout}, {31'b0, vecs[i].exp_c});
      chk($sformatf("v%0d_zero", i), {31'b0, bus.zero}, {31'b0, vecs[i].exp_z});
      chk($sformatf("v%0d_err", i), {31'b0, bus.err}, {31'b0, vecs[i].exp_e});
      chk($sformatf("v%0d_done_in_ready", i), {31'b0, bus.in_ready}, 32'd0);
      release_out();
    end

    // Backpressure, with operands scribbled during RUN.
    start_op(1'b0, 4'h9, 1'b0, 16'h1111, 16'h2222);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.in_valid = 1'b1;
    wait_done(lat);
    bus.in_valid = 1'b0;
    chk("bp_latency", lat, 32'd4);
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_f", {16'b0, bus.f}, 32'h3333);
      chk("bp_flags", {29'b0, bus.crout, bus.zero, bus.err}, 32'd0);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_state", {30'b0, state}, 32'd2);
      @(posedge clk); #1;
    end
    release_out();

    // Reset during the second RUN cycle aborts without output.
    start_op(1'b0, 4'h9, 1'b0, 16'hFFFF, 16'h0001);
    @(posedge clk); #1;
    chk("mid_state_run", {30'b0, state}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_f", {16'b0, bus.f}, 32'd0);
    chk("mid_rst_state", {30'b0, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_output", {31'b0, bus.out_valid}, 32'd0);
    start_op(1'b0, 4'h9, 1'b0, 16'h0001, 16'h0001);
    wait_done(lat);
    chk("after_rst_latency", lat, 32'd4);
    chk("after_rst_f", {16'b0, bus.f}, 32'h0002);
    chk("after_rst_flags", {29'b0, bus.crout, bus.zero, bus.err}, 32'd0);
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
